// File: rtl/pipeline_latch_chain_if.sv
// Handshake/bus bundle between fetch, stage consumers and the pipeline latch chain.
// master drives fetch, stall, flush and stats control; slave is the latch chain itself.
interface pipeline_latch_chain_if #(
    parameter int STAGES = 4,
    parameter int WIDTH  = 32,
    parameter int IDXW   = $clog2(STAGES + 1),
    parameter int CNTW   = 16
);
    logic                      in_valid;
    logic [WIDTH-1:0]          in_data;
    logic                      in_ready;
    logic [STAGES-1:0]         stall_req;
    logic                      flush_valid;
    logic [IDXW-1:0]           flush_idx;
    logic [STAGES*WIDTH-1:0]   stage_data;
    logic [STAGES-1:0]         stage_valid;
    logic                      retire_valid;
    logic [IDXW-1:0]           occupancy;
    logic                      clr_stats;
    logic [CNTW-1:0]           stall_count;

    modport master (
        output in_valid, in_data, stall_req, flush_valid, flush_idx, clr_stats,
        input  in_ready, stage_data, stage_valid, retire_valid, occupancy, stall_count
    );

    modport slave (
        input  in_valid, in_data, stall_req, flush_valid, flush_idx, clr_stats,
        output in_ready, stage_data, stage_valid, retire_valid, occupancy, stall_count
    );
endinterface

// File: rtl/pipeline_latch_chain.sv
// Purpose: STAGES valid-tagged pipeline latches (IF/ID .. MEM/WB) with stall, bubble collapse and flush.
// Latency: one edge per latch; a word accepted at edge N sits in latch i after edge N+i.
// Backpressure: stalls ripple upstream only through valid latches; in_ready low when latch 0 holds or on flush.
module pipeline_latch_chain #(
    parameter int STAGES = 4,
    parameter int WIDTH  = 32,
    parameter int IDXW   = $clog2(STAGES + 1),
    parameter int CNTW   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipeline_latch_chain_if.slave bus
);
    logic [STAGES-1:0]            valid_q;
    logic [STAGES-1:0]            valid_d;
    logic [STAGES-1:0][WIDTH-1:0] data_q;
    logic [STAGES-1:0][WIDTH-1:0] data_d;
    logic [STAGES-1:0]            hold;
    logic [STAGES-1:0]            kill;
    logic [IDXW-1:0]              flush_lim;
    logic [IDXW-1:0]              occ;
    logic [CNTW-1:0]              stall_cnt_q;
    logic                         in_ready;
    logic                         blocked;

    // A latch holds only while it carries a word; empty latches break the chain so bubbles collapse.
    always_comb begin
        logic h;
        h    = 1'b0;
        hold = '0;
        for (int i = STAGES - 1; i >= 0; i--) begin
            h       = valid_q[i] & (bus.stall_req[i] | h);
            hold[i] = h;
        end
    end

    assign flush_lim = (bus.flush_idx > IDXW'(STAGES)) ? IDXW'(STAGES) : bus.flush_idx;

    always_comb begin
        kill = '0;
        for (int j = 0; j < STAGES; j++) begin
            kill[j] = bus.flush_valid & (IDXW'(j) < flush_lim);
        end
    end

    assign in_ready = ~hold[0] & ~bus.flush_valid;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (!hold[0]) begin
            data_d[0]  = bus.in_data;
            valid_d[0] = bus.in_valid & ~bus.flush_valid;
        end
        for (int i = 1; i < STAGES; i++) begin
            if (!hold[i]) begin
                data_d[i]  = data_q[i-1];
                valid_d[i] = valid_q[i-1] & ~hold[i-1];
            end
        end
        // Flush overrides both hold and load on the younger latches.
        for (int j = 0; j < STAGES; j++) begin
            if (kill[j]) begin
                valid_d[j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign blocked = bus.in_valid & ~in_ready & ~bus.flush_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (bus.clr_stats) begin
            stall_cnt_q <= '0;
        end else if (blocked && (stall_cnt_q != {CNTW{1'b1}})) begin
            stall_cnt_q <= stall_cnt_q + CNTW'(1);
        end
    end

    always_comb begin
        occ = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ = occ + IDXW'(valid_q[i]);
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.retire_valid = valid_q[STAGES-1] & ~bus.stall_req[STAGES-1];
    assign bus.stage_data   = data_q;
    assign bus.stage_valid  = valid_q;
    assign bus.occupancy    = occ;
    assign bus.stall_count  = stall_cnt_q;
endmodule

// File: doc/pipeline_latch_chain.md
# pipeline_latch_chain

Parametrised replacement for the hand-instantiated IF/ID, ID/EX, EX/MEM and MEM/WB latches of the LC-3b pipelined CPU. It provides STAGES payload registers, each with a valid bit, and handles per-stage stall requests with backpressure. Bubbles are squeezed out on stalls: an empty latch may always be filled. Branch flush kills younger stages, and a stall-cycle counter is included for performance measurement.

## Interface
Parameters:
- STAGES, 4, number of pipeline latches; latch 0 is IF/ID, latch STAGES-1 is MEM/WB; must be ≥2
- WIDTH, 32, payload bits per latch (IR + PC by default)
- IDXW, $clog2(STAGES+1), width of flush_idx
- CNTW, 16, stall counter width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- in_valid  in  1  fetch presents a word
- in_data  in  WIDTH  fetched payload
- in_ready  out  1  latch 0 accepts in_data this cycle
- stall_req  in  STAGES  bit i: logic consuming latch i is not finished (e.g. memory wait)
- flush_valid  in  1  branch/flush resolved this cycle
- flush_idx  in  IDXW  latches 0..flush_idx-1 are killed; values >STAGES are treated as STAGES
- stage_data  out  STAGES*WIDTH  latch i occupies bits [i*WIDTH +: WIDTH]
- stage_valid  out  STAGES  valid bit per latch
- retire_valid  out  1  latch STAGES-1 is consumed this cycle
- occupancy  out  IDXW  count of set stage_valid bits
- clr_stats  in  1  synchronous clear of stall_count
- stall_count  out  CNTW  saturating count of fetch-blocked cycles

## Operation
- Hold chain, combinational:
  - hold[STAGES-1] = valid[STAGES-1] & stall_req[STAGES-1].
  - hold[i] = valid[i] & (stall_req[i] | hold[i+1]).
  - An invalid latch never holds, regardless of downstream state (bubble collapse).
- Latch update, for i ≥ 1:
  - If hold[i]: data and valid are retained.
  - Otherwise: data[i] ← data[i-1]; valid[i] ← valid[i-1] & ~hold[i-1].
  - A held producer therefore injects a bubble.
- Latch 0:
  - in_ready = ~hold[0] & ~flush_valid.
  - If ~hold[0]: data[0] ← in_data; valid[0] ← in_valid & ~flush_valid.
- Flush:
  - When flush_valid is set, valid[j] ← 0 for every j < flush_idx, overriding both hold and load.
  - Latches j ≥ flush_idx update normally.
  - flush_idx = 0 only drops the incoming word.
- Retire: retire_valid = valid[STAGES-1] & ~stall_req[STAGES-1]. The consumer samples stage_data of the last latch in the same cycle.
- stall_count:
  - Increments when in_valid & ~in_ready & ~flush_valid.
  - Saturates at all ones.
  - clr_stats takes priority over increment; the next value is 0.
- occupancy is the popcount of the registered valid bits.
- Payload of an invalid latch is don't-care for consumers. It still loads whenever the latch is not held.

## Timing
- Reset (async assert, sync-safe deassert by the system): all valid bits 0; all data 0; stall_count 0.
- After reset, combinational outputs settle as follows: in_ready 1 (unless flush_valid is set), retire_valid 0, occupancy 0.
- Latency: a word accepted at edge N appears in latch i after edge N+i (i = 0..STAGES-1), when nothing holds.
- in_ready, retire_valid and hold are combinational from stall_req, flush_valid and registered valids. Nothing combinational depends on in_valid or in_data.
- Simultaneous events:
  - Flush and stall on the same latch: flush wins (valid cleared).
  - Stall on latch k with k ≥ flush_idx: latch k still holds.
- Full pipeline with stall_req[STAGES-1]=1: all latches hold and in_ready=0.
- Fully empty pipeline: in_ready=1 even with every stall_req bit set.

## Test plan
- Streaming: STAGES=4, in_valid=1 with in_data = 0x1000+n each cycle, no stalls → first retire_valid after 4 edges with data 0x1000; then one retire per cycle in order; occupancy 4.
- Stall with bubble collapse: full pipeline, stall_req[2]=1 for 3 cycles → latches 0..2 hold and latch 3 gets a bubble (valid 0) on the next edge. in_ready=0 throughout. On release, order resumes with no loss or duplication.
- Stall into empty space: reset, then stall_req=4'b1111 while feeding 3 words → in_ready stays 1 until latch 0 is valid, then 0. Only latch 0 fills.
- Flush: full pipeline, flush_valid=1 with flush_idx=2 → on the next edge valid[0]=valid[1]=0, latch 2 advances, the incoming word is dropped and in_ready=0 that cycle. occupancy drops to 2 (latches 2 and 3 valid) after the edge.
- Counters: hold in_ready low with in_valid=1 for 5 cycles → stall_count=5. Then clr_stats together with a blocked cycle gives 0. With CNTW=2, 6 blocked cycles saturate at 3.
- Async reset mid-stream: drop rst_n between edges → all stage_valid go 0 and stall_count goes 0 immediately, without a clock edge. Resume streaming after release.
